mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares one synchronous single-port memory between the instruction-fetch port and the load/store data port of the processor core.
- Sits between the core and the unified RAM in the minimal SOPC, replacing the direct ROM hookup.
- Sequences each access through a fixed state machine and raises a stall request while any requester is waiting.

Parameters:
- ADDR_W, 32, address width for both ports and the memory.
- DATA_W, 32, data width; byte-select width is DATA_W/8.
- MEM_LATENCY, 1, cycles from the memory command cycle to valid mem_rdata. Legal range is 1..15.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- if_req  in  1  fetch request; held high until if_ready.
- if_addr  in  ADDR_W  fetch address; held stable while if_req.
- if_ready  out  1  one-cycle pulse: fetch done, if_inst valid.
- if_inst  out  DATA_W  registered fetch data.
- d_req  in  1  data request; held high until d_ready.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  store data.
- d_sel  in  DATA_W/8  byte enables.
- d_ready  out  1  one-cycle pulse: data access done.
- d_rdata  out  DATA_W  registered load data.
- stall_o  out  1  pipeline stall request.
- mem_ce  out  1  memory command strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_sel  out  DATA_W/8  memory byte enables.
- mem_rdata  in  DATA_W  memory read data.

Behaviour:
- Reset: state IDLE, counter 0, last_grant = FETCH.
- Reset values of outputs: all registered outputs 0, including if_inst, d_rdata, mem_addr, mem_wdata and mem_sel.
- Reset is asynchronous; asserting it mid-access aborts the access immediately, and mem_ce, mem_we and both ready outputs fall without waiting for a clock edge.
- State IDLE:
  - If d_req or if_req is high, select a grant, latch that port's addr/we/wdata/sel into command registers, and go to ACCESS.
  - Fetch commands latch we=0 and sel=all ones.
  - Fixed priority: data wins over fetch.
- State ACCESS (exactly 1 cycle):
  - mem_ce=1; mem_we = latched we; mem_addr, mem_wdata and mem_sel driven from the command registers.
  - Load counter with MEM_LATENCY-1, then go to WAIT.
- State WAIT (exactly MEM_LATENCY cycles):
  - mem_ce=0 and mem_we=0; mem_addr/mem_wdata/mem_sel hold their values.
  - Counter decrements each cycle. When the counter is 0:
    - for a read, capture mem_rdata into if_inst (fetch grant) or d_rdata (data grant); the other data register is unchanged;
    - go to RESP.
- State RESP (1 cycle): assert the granted port's ready, then go to IDLE.
- Stores: d_rdata is unchanged; d_ready still pulses in RESP.
- Latency: a request seen in IDLE in cycle 0 gets ready in cycle MEM_LATENCY+2.
- Throughput: one access per MEM_LATENCY+3 cycles.
- stall_o is combinational: (if_req & ~if_ready) | (d_req & ~d_ready).
- Requests arriving while not in IDLE wait; they are never dropped.
- If a request is withdrawn mid-access, the access still completes and the ready pulse is still issued; the requester ignores it.
- A new request is not accepted in RESP; the earliest acceptance is the following IDLE cycle.
- last_grant updates on every IDLE→ACCESS transition.

Optional Feature:
- Macro: MEM_ARBITER_RR_EN.
- Defined: when d_req and if_req are both high in IDLE, grant the port opposite to last_grant. With last_grant reset to FETCH, the first tie goes to data. A single requester is always granted regardless of last_grant.
- Undefined: data strictly beats fetch, and last_grant is unused.

Test Plan:
- MEM_LATENCY=1, single fetch at if_addr=0x100, memory returns 0x3402_0001 → mem_ce high in cycle 1 with mem_addr=0x100, if_ready in cycle 3, if_inst=0x3402_0001, stall_o high in cycles 0-2 and low in cycle 3.
- Store d_addr=0x40, d_wdata=0xDEAD_BEEF, d_sel=0b0011 → cycle 1 shows mem_we=1 and mem_sel=0b0011; d_ready in cycle 3; d_rdata unchanged.
- if_req and d_req raised in the same cycle, both held:
  - without the macro: data served first (d_ready cycle 3), then fetch (if_ready cycle 7);
  - with MEM_ARBITER_RR_EN, repeating the tie: grant order D, F, D, F.
- MEM_LATENCY=4, load from 0x80 → mem_ce in cycle 1, mem_rdata captured at the end of cycle 5, d_ready in cycle 6.
- rst asserted asynchronously during WAIT of a fetch → mem_ce, if_ready and stall_o drop without a clock edge. After release, state is IDLE, if_inst=0, and a new request completes with the normal latency.
- if_req dropped during ACCESS → if_ready still pulses in cycle 3; the arbiter returns to IDLE in cycle 4 and no new ACCESS occurs.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_arbiter_if
// Bundles the core-side fetch/data handshakes and the single-port memory
// command/response bus that mem_arbiter sits between.
//   slave  : the arbiter's view (takes requests and mem_rdata; drives ready,
//            read data, stall and the memory command).
//   master : the environment's view (core requesters plus the memory).
// Signals:
//   if_req/if_addr -> if_ready/if_inst           instruction fetch port
//   d_req/d_we/d_addr/d_wdata/d_sel -> d_ready/d_rdata   load/store port
//   stall_o                                      pipeline stall request
//   mem_ce/mem_we/mem_addr/mem_wdata/mem_sel, mem_rdata  memory bus
// ---------------------------------------------------------------------------
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                  if_req;
  logic [ADDR_W-1:0]     if_addr;
  logic                  if_ready;
  logic [DATA_W-1:0]     if_inst;
  logic                  d_req;
  logic                  d_we;
  logic [ADDR_W-1:0]     d_addr;
  logic [DATA_W-1:0]     d_wdata;
  logic [DATA_W/8-1:0]   d_sel;
  logic                  d_ready;
  logic [DATA_W-1:0]     d_rdata;
  logic                  stall_o;
  logic                  mem_ce;
  logic                  mem_we;
  logic [ADDR_W-1:0]     mem_addr;
  logic [DATA_W-1:0]     mem_wdata;
  logic [DATA_W/8-1:0]   mem_sel;
  logic [DATA_W-1:0]     mem_rdata;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_sel, mem_rdata,
    output if_ready, if_inst, d_ready, d_rdata, stall_o,
           mem_ce, mem_we, mem_addr, mem_wdata, mem_sel
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_sel, mem_rdata,
    input  if_ready, if_inst, d_ready, d_rdata, stall_o,
           mem_ce, mem_we, mem_addr, mem_wdata, mem_sel
  );
endinterface

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
// Shares one synchronous single-port memory between the instruction-fetch
// port and the load/store port. Each access runs IDLE -> ACCESS (1 cycle,
// command on the bus) -> WAIT (MEM_LATENCY cycles) -> RESP (1 cycle ready
// pulse), so a request seen in IDLE at cycle 0 gets ready at MEM_LATENCY+2.
// Ports:
//   clk   system clock, rising edge
//   rst   asynchronous active-high reset
//   bus   mem_arbiter_if.slave (fetch port, data port, stall, memory bus)
// Parameters: ADDR_W, DATA_W (byte enables DATA_W/8), MEM_LATENCY (1..15).
// Build option: MEM_ARBITER_RR_EN -- when both ports request in IDLE, grant
// the port opposite to the previous grant; otherwise data beats fetch.
// ---------------------------------------------------------------------------
module mem_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MEM_LATENCY = 1
) (
  input  logic           clk,
  input  logic           rst,
  mem_arbiter_if.slave   bus
);

  localparam int         SEL_W  = DATA_W / 8;
  localparam logic [3:0] LAT_M1 = 4'(MEM_LATENCY - 1);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WAIT, S_RESP} state_t;
  typedef enum logic {G_FETCH, G_DATA} grant_t;

  state_t              r_state;
  state_t              w_next;
  grant_t              r_grant;
  grant_t              w_grant;
  logic                w_accept;
  logic                w_capture;
  logic                w_mem_ce;
  logic                w_mem_we;
  logic                w_if_ready;
  logic                w_d_ready;

  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [SEL_W-1:0]    r_sel;
  logic [3:0]          r_cnt;
  logic [DATA_W-1:0]   r_if_inst;
  logic [DATA_W-1:0]   r_d_rdata;

`ifdef MEM_ARBITER_RR_EN
  grant_t              r_last;
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next state, grant selection and strobes
  always_comb begin
    w_next     = r_state;
    w_accept   = 1'b0;
    w_grant    = G_FETCH;
    w_capture  = 1'b0;
    w_mem_ce   = 1'b0;
    w_mem_we   = 1'b0;
    w_if_ready = 1'b0;
    w_d_ready  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.d_req || bus.if_req) begin
          w_accept = 1'b1;
          w_next   = S_ACCESS;
`ifdef MEM_ARBITER_RR_EN
          if (bus.d_req && bus.if_req) begin
            if (r_last == G_FETCH) w_grant = G_DATA;
            else                   w_grant = G_FETCH;
          end else if (bus.d_req) begin
            w_grant = G_DATA;
          end
`else
          if (bus.d_req) w_grant = G_DATA;
`endif
        end
      end
      S_ACCESS: begin
        w_mem_ce = 1'b1;
        w_mem_we = r_we;
        w_next   = S_WAIT;
      end
      S_WAIT: begin
        if (r_cnt == '0) begin
          w_capture = ~r_we;
          w_next    = S_RESP;
        end
      end
      S_RESP: begin
        w_if_ready = (r_grant == G_FETCH);
        w_d_ready  = (r_grant == G_DATA);
        w_next     = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Command registers, latency counter and read-data capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_grant   <= G_FETCH;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_sel     <= '0;
      r_cnt     <= '0;
      r_if_inst <= '0;
      r_d_rdata <= '0;
    end else begin
      if (w_accept) begin
        r_grant <= w_grant;
        if (w_grant == G_DATA) begin
          r_we    <= bus.d_we;
          r_addr  <= bus.d_addr;
          r_wdata <= bus.d_wdata;
          r_sel   <= bus.d_sel;
        end else begin
          r_we    <= 1'b0;
          r_addr  <= bus.if_addr;
          r_wdata <= '0;
          r_sel   <= '1;
        end
      end
      if (r_state == S_ACCESS)                    r_cnt <= LAT_M1;
      else if (r_state == S_WAIT && r_cnt != '0)  r_cnt <= r_cnt - 4'd1;
      if (w_capture) begin
        if (r_grant == G_FETCH) r_if_inst <= bus.mem_rdata;
        else                    r_d_rdata <= bus.mem_rdata;
      end
    end
  end

`ifdef MEM_ARBITER_RR_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           r_last <= G_FETCH;
    else if (w_accept) r_last <= w_grant;
  end
`endif

  assign bus.mem_ce    = w_mem_ce;
  assign bus.mem_we    = w_mem_we;
  assign bus.mem_addr  = r_addr;
  assign bus.mem_wdata = r_wdata;
  assign bus.mem_sel   = r_sel;
  assign bus.if_ready  = w_if_ready;
  assign bus.d_ready   = w_d_ready;
  assign bus.if_inst   = r_if_inst;
  assign bus.d_rdata   = r_d_rdata;

  // Masked by rst so an aborted access releases the pipeline immediately.
  assign bus.stall_o = ~rst & ((bus.if_req & ~w_if_ready) | (bus.d_req & ~w_d_ready));

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int SW    = DW / 8;
  localparam int LAT_A = 1;
  localparam int LAT_B = 4;

  logic clk = 1'b0;
  logic rst;
  logic mem_init;
  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) u_if_a ();
  mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) u_if_b ();

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LATENCY(LAT_A)) u_dut_a (
    .clk(clk), .rst(rst), .bus(u_if_a)
  );
  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LATENCY(LAT_B)) u_dut_b (
    .clk(clk), .rst(rst), .bus(u_if_b)
  );

  function automatic logic [DW-1:0] init_word(int unsigned i);
    logic [7:0] b;
    b = 8'(i);
    if (i == 32'h40) return 32'h3402_0001;
    return {b, ~b, b ^ 8'h5A, 8'hC3};
  endfunction

  // Environment memory: byte-masked writes, reads valid LAT cycles after command,
  // random garbage otherwise so mistimed captures are visible.
  logic [DW-1:0] env_mem [256];
  logic [DW-1:0] pipe_a  [LAT_A];
  logic [DW-1:0] pipe_b  [LAT_B];

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) env_mem[i] <= init_word(i);
    end else if (u_if_a.mem_ce && u_if_a.mem_we) begin
      for (int b = 0; b < SW; b++)
        if (u_if_a.mem_sel[b])
          env_mem[u_if_a.mem_addr[9:2]][8*b +: 8] <= u_if_a.mem_wdata[8*b +: 8];
    end
    pipe_a[0] <= (u_if_a.mem_ce && !u_if_a.mem_we) ? env_mem[u_if_a.mem_addr[9:2]] : $urandom;
    for (int i = 1; i < LAT_A; i++) pipe_a[i] <= pipe_a[i-1];
    pipe_b[0] <= (u_if_b.mem_ce && !u_if_b.mem_we) ? env_mem[u_if_b.mem_addr[9:2]] : $urandom;
    for (int i = 1; i < LAT_B; i++) pipe_b[i] <= pipe_b[i-1];
  end
  assign u_if_a.mem_rdata = pipe_a[LAT_A-1];
  assign u_if_b.mem_rdata = pipe_b[LAT_B-1];

  // Transaction-level reference model for DUT A
  int unsigned   n_tests = 0;
  int unsigned   n_fail  = 0;
  int unsigned   cyc;
  bit            act;
  int unsigned   acc_t;
  bit            g_data;
  bit            c_we;
  logic [AW-1:0] c_addr;
  logic [DW-1:0] c_wdata;
  logic [SW-1:0] c_sel;
  bit            last_data;
  bit            m_ifr, m_dr;
  logic [DW-1:0] m_if_inst, m_d_rdata;
  logic [DW-1:0] ref_mem [256];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    act = 0; last_data = 0; m_ifr = 0; m_dr = 0;
    m_if_inst = '0; m_d_rdata = '0;
  endtask

  // Check one cycle of DUT A at the falling edge, advance the model, then
  // move to 1 time unit after the next rising edge.
  task automatic cycle();
    bit e_ce, e_we, e_ifr, e_dr;
    int unsigned ph;
    @(negedge clk);
    e_ce = 0; e_we = 0; e_ifr = 0; e_dr = 0; ph = 0;
    if (act) begin
      ph = cyc - acc_t;
      if (ph == 1) begin
        e_ce = 1; e_we = c_we;
        if (c_we) check("mem_wdata", u_if_a.mem_wdata, c_wdata);
      end
      if (ph >= 1) begin
        check("mem_addr", u_if_a.mem_addr, c_addr);
        check("mem_sel", u_if_a.mem_sel, c_sel);
      end
      if (ph == LAT_A + 2) begin
        e_ifr = !g_data; e_dr = g_data;
        if (!c_we) begin
          if (g_data) m_d_rdata = ref_mem[c_addr[9:2]];
          else        m_if_inst = ref_mem[c_addr[9:2]];
        end
      end
    end
    check("mem_ce", u_if_a.mem_ce, e_ce);
    check("mem_we", u_if_a.mem_we, e_we);
    check("if_ready", u_if_a.if_ready, e_ifr);
    check("d_ready", u_if_a.d_ready, e_dr);
    check("stall_o", u_if_a.stall_o, (u_if_a.if_req & !e_ifr) | (u_if_a.d_req & !e_dr));
    check("if_inst", u_if_a.if_inst, m_if_inst);
    check("d_rdata", u_if_a.d_rdata, m_d_rdata);
    m_ifr = e_ifr; m_dr = e_dr;
    if (act && ph == LAT_A + 2) begin
      act = 0;
    end else if (!act && (u_if_a.if_req || u_if_a.d_req)) begin
`ifdef MEM_ARBITER_RR_EN
      if (u_if_a.if_req && u_if_a.d_req) g_data = !last_data;
      else                               g_data = u_if_a.d_req;
`else
      g_data = u_if_a.d_req;
`endif
      last_data = g_data; act = 1; acc_t = cyc;
      if (g_data) begin
        c_we = u_if_a.d_we; c_addr = u_if_a.d_addr; c_wdata = u_if_a.d_wdata; c_sel = u_if_a.d_sel;
        if (c_we)
          for (int b = 0; b < SW; b++)
            if (c_sel[b]) ref_mem[c_addr[9:2]][8*b +: 8] = c_wdata[8*b +: 8];
      end else begin
        c_we = 0; c_addr = u_if_a.if_addr; c_wdata = '0; c_sel = '1;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Run until both requesters are served (dropping each on its ready) and the
  // arbiter is idle; an exhausted budget is reported as a failure.
  task automatic drain(input int unsigned max);
    bit pend;
    for (int k = 0; k < max; k++) begin
      cycle();
      if (m_ifr) u_if_a.if_req = 0;
      if (m_dr)  u_if_a.d_req  = 0;
      if (!u_if_a.if_req && !u_if_a.d_req && !act) break;
    end
    pend = u_if_a.if_req | u_if_a.d_req | act;
    check("drain_timeout", pend, 0);
  endtask

  function automatic logic [AW-1:0] rnd_addr();
    return {22'd0, 8'($urandom), 2'b00};
  endfunction

  initial begin
    rst = 1; mem_init = 1; cyc = 0; model_reset();
    u_if_a.if_req = 0; u_if_a.if_addr = '0; u_if_a.d_req = 0; u_if_a.d_we = 0;
    u_if_a.d_addr = '0; u_if_a.d_wdata = '0; u_if_a.d_sel = '0;
    u_if_b.if_req = 0; u_if_b.if_addr = '0; u_if_b.d_req = 0; u_if_b.d_we = 0;
    u_if_b.d_addr = '0; u_if_b.d_wdata = '0; u_if_b.d_sel = '0;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
    @(posedge clk); @(posedge clk); #1;
    mem_init = 0;

    // Reset state
    check("rst_mem_ce", u_if_a.mem_ce, 0);
    check("rst_mem_we", u_if_a.mem_we, 0);
    check("rst_if_ready", u_if_a.if_ready, 0);
    check("rst_d_ready", u_if_a.d_ready, 0);
    check("rst_stall", u_if_a.stall_o, 0);
    check("rst_if_inst", u_if_a.if_inst, 0);
    check("rst_d_rdata", u_if_a.d_rdata, 0);
    check("rst_mem_addr", u_if_a.mem_addr, 0);
    check("rst_mem_wdata", u_if_a.mem_wdata, 0);
    check("rst_mem_sel", u_if_a.mem_sel, 0);
    @(posedge clk); #1;
    rst = 0;

    // Single fetch from 0x100
    u_if_a.if_req = 1; u_if_a.if_addr = 32'h100;
    drain(20);
    check("fetch_inst", u_if_a.if_inst, 32'h3402_0001);

    // Store 0xDEADBEEF to 0x40 with sel 0011
    u_if_a.d_req = 1; u_if_a.d_we = 1; u_if_a.d_addr = 32'h40;
    u_if_a.d_wdata = 32'hDEAD_BEEF; u_if_a.d_sel = 4'b0011;
    drain(20);
    check("store_rdata", u_if_a.d_rdata, 0);

    // Load back the stored word, then a simultaneous tie
    u_if_a.d_req = 1; u_if_a.d_we = 0;
    drain(20);
    u_if_a.d_req = 1; u_if_a.d_addr = 32'h104; u_if_a.if_req = 1; u_if_a.if_addr = 32'h100;
    drain(30);

    // Continuous tie: both held, each re-requesting right after its ready
    u_if_a.d_req = 1; u_if_a.if_req = 1;
    for (int k = 0; k < 4 * (LAT_A + 3); k++) begin
      cycle();
      if (m_dr)  u_if_a.d_addr  = rnd_addr();
      if (m_ifr) u_if_a.if_addr = rnd_addr();
    end
    drain(30);

    // Fetch withdrawn during ACCESS still completes; no second access follows
    u_if_a.if_req = 1; u_if_a.if_addr = 32'h80;
    cycle();
    u_if_a.if_req = 0;
    for (int k = 0; k < 6; k++) cycle();

    // Random traffic on both ports
    for (int k = 0; k < 1500; k++) begin
      cycle();
      if (u_if_a.if_req) begin
        if (m_ifr) begin
          u_if_a.if_req = 1'($urandom_range(0, 1));
          u_if_a.if_addr = rnd_addr();
        end else if ($urandom_range(0, 31) == 0) u_if_a.if_req = 0;
      end else if ($urandom_range(0, 1) == 1) begin
        u_if_a.if_req = 1; u_if_a.if_addr = rnd_addr();
      end
      if (u_if_a.d_req && !m_dr) begin
        if ($urandom_range(0, 31) == 0) u_if_a.d_req = 0;
      end else if (m_dr || $urandom_range(0, 1) == 1) begin
        u_if_a.d_req = 1'($urandom_range(0, 1));
        u_if_a.d_we = 1'($urandom_range(0, 1));
        u_if_a.d_addr = rnd_addr();
        u_if_a.d_wdata = $urandom;
        u_if_a.d_sel = 4'($urandom);
      end
    end
    drain(40);

    // Asynchronous reset in ACCESS, WAIT and RESP of a fetch
    for (int p = 1; p <= 3; p++) begin
      u_if_a.if_req = 1; u_if_a.if_addr = 32'h100;
      for (int k = 0; k < p; k++) cycle();
      #2 rst = 1;
      #1;
      check("abort_mem_ce", u_if_a.mem_ce, 0);
      check("abort_mem_we", u_if_a.mem_we, 0);
      check("abort_if_ready", u_if_a.if_ready, 0);
      check("abort_d_ready", u_if_a.d_ready, 0);
      check("abort_stall", u_if_a.stall_o, 0);
      check("abort_if_inst", u_if_a.if_inst, 0);
      u_if_a.if_req = 0;
      @(posedge clk); @(posedge clk); #1;
      rst = 0; model_reset();
      u_if_a.if_req = 1; u_if_a.if_addr = 32'h104;
      drain(20);
    end

    // DUT B (MEM_LATENCY=4): load from 0x80
    u_if_b.d_req = 1; u_if_b.d_we = 0; u_if_b.d_addr = 32'h80; u_if_b.d_sel = 4'hF;
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      check("b_mem_ce", u_if_b.mem_ce, (k == 1));
      check("b_d_ready", u_if_b.d_ready, (k == LAT_B + 2));
      if (k == 1) check("b_mem_addr", u_if_b.mem_addr, 32'h80);
      if (k == LAT_B + 2) check("b_d_rdata", u_if_b.d_rdata, ref_mem[32]);
      @(posedge clk); #1;
      if (k == LAT_B + 2) u_if_b.d_req = 0;
    end
    check("b_final_rdata", u_if_b.d_rdata, ref_mem[32]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
